// File: rtl/dark_bus_arbiter_if.sv
// Darkbus arbiter signal bundle: two requesters (fe, me), one target (t),
// plus grant/err status.
// Modport master is the arbiter's view; modport slave is the surrounding
// requesters/target view.
interface dark_bus_arbiter_if;
    logic        fe_en;
    logic        fe_rw;
    logic [3:0]  fe_be;
    logic [31:0] fe_addr;
    logic [31:0] fe_wdata;
    logic [31:0] fe_rdata;
    logic        fe_valid;

    logic        me_en;
    logic        me_rw;
    logic [3:0]  me_be;
    logic [31:0] me_addr;
    logic [31:0] me_wdata;
    logic [31:0] me_rdata;
    logic        me_valid;

    logic        t_en;
    logic        t_rw;
    logic [3:0]  t_be;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        t_valid;

    logic [1:0]  grant;
    logic        err;

    modport master (
        input  fe_en, fe_rw, fe_be, fe_addr, fe_wdata,
        output fe_rdata, fe_valid,
        input  me_en, me_rw, me_be, me_addr, me_wdata,
        output me_rdata, me_valid,
        output t_en, t_rw, t_be, t_addr, t_wdata,
        input  t_rdata, t_valid,
        output grant, err
    );

    modport slave (
        output fe_en, fe_rw, fe_be, fe_addr, fe_wdata,
        input  fe_rdata, fe_valid,
        output me_en, me_rw, me_be, me_addr, me_wdata,
        input  me_rdata, me_valid,
        input  t_en, t_rw, t_be, t_addr, t_wdata,
        output t_rdata, t_valid,
        input  grant, err
    );
endinterface

// File: rtl/dark_bus_arbiter.sv
// dark_bus_arbiter: two-requester (fetch, memory stage), one-target darkbus
// arbiter with registered grant, per-transaction lock and watchdog timeout.
// Optional feature macro: DARK_ARB_RR_EN selects round-robin tie-break;
// without it the memory stage always wins ties.
//
// state  | meaning
// IDLE   | no owner, waiting for a request
// GNT_FE | fetch owns the target, waiting for t_valid or timeout
// GNT_ME | memory stage owns the target, waiting for t_valid or timeout
module dark_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic clk,
    input  logic res,
    dark_bus_arbiter_if.master bus
);

    // State encoding doubles as the grant code.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_FE = 2'b01,
        GNT_ME = 2'b10
    } state_t;

    localparam logic [16:0] TMO_W = 17'(TIMEOUT);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        t_en_q;
    logic        t_rw_q;
    logic [3:0]  t_be_q;
    logic [31:0] t_addr_q;
    logic [31:0] t_wdata_q;
    logic        err_q;
    logic        last_me_q;

    logic        busy;
    logic        timeout_hit;
    logic        tie_me;
    logic        pick_me_d;

    assign busy = (state_q == GNT_FE) || (state_q == GNT_ME);
    // cnt_q counts completed grant cycles, so the current cycle is cnt_q+1;
    // a t_valid in the deadline cycle still wins.
    assign timeout_hit = busy && !bus.t_valid && (({1'b0, cnt_q} + 17'd1) == TMO_W);

    // Tie-break choice and winner selection for the IDLE state.
    always_comb begin
`ifdef DARK_ARB_RR_EN
        tie_me = !last_me_q;
`else
        tie_me = 1'b1;
`endif
        pick_me_d = bus.me_en && (!bus.fe_en || tie_me);
    end

    // Arbiter FSM with latched target request, watchdog and sticky error.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            t_en_q    <= 1'b0;
            t_rw_q    <= 1'b0;
            t_be_q    <= '0;
            t_addr_q  <= '0;
            t_wdata_q <= '0;
            err_q     <= 1'b0;
            last_me_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.fe_en || bus.me_en) begin
                        t_en_q    <= 1'b1;
                        last_me_q <= pick_me_d;
                        if (pick_me_d) begin
                            state_q   <= GNT_ME;
                            t_rw_q    <= bus.me_rw;
                            t_be_q    <= bus.me_be;
                            t_addr_q  <= bus.me_addr;
                            t_wdata_q <= bus.me_wdata;
                        end else begin
                            state_q   <= GNT_FE;
                            t_rw_q    <= bus.fe_rw;
                            t_be_q    <= bus.fe_be;
                            t_addr_q  <= bus.fe_addr;
                            t_wdata_q <= bus.fe_wdata;
                        end
                    end
                end
                GNT_FE, GNT_ME: begin
                    if (bus.t_valid || timeout_hit) begin
                        state_q <= IDLE;
                        t_en_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    t_en_q  <= 1'b0;
                end
            endcase
        end
    end

    // Completion pass-through to the owner; the other requester sees zeros.
    always_comb begin
        bus.fe_valid = 1'b0;
        bus.fe_rdata = '0;
        bus.me_valid = 1'b0;
        bus.me_rdata = '0;
        if (state_q == GNT_FE) begin
            bus.fe_valid = bus.t_valid || timeout_hit;
            bus.fe_rdata = timeout_hit ? ERR_DATA : bus.t_rdata;
        end else if (state_q == GNT_ME) begin
            bus.me_valid = bus.t_valid || timeout_hit;
            bus.me_rdata = timeout_hit ? ERR_DATA : bus.t_rdata;
        end
    end

    assign bus.t_en    = t_en_q;
    assign bus.t_rw    = t_rw_q;
    assign bus.t_be    = t_be_q;
    assign bus.t_addr  = t_addr_q;
    assign bus.t_wdata = t_wdata_q;
    assign bus.grant   = state_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_dark_bus_arbiter.sv
// Testbench for dark_bus_arbiter (TIMEOUT = 8): directed transaction table
// plus hand-written tie and mid-transaction reset sequences.
module tb_dark_bus_arbiter;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dark_bus_arbiter_if bus();

    dark_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        me;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // grant cycle (1-based) in which t_valid is driven
        logic [31:0] rdata;      // target read data driven during the grant
        logic [31:0] exp_rdata;  // expected requester rdata at completion
        logic        exp_err;    // expected err after completion
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic me, input logic en, input logic rw, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (me) begin
            bus.me_en = en; bus.me_rw = rw; bus.me_be = be; bus.me_addr = addr; bus.me_wdata = wdata;
        end else begin
            bus.fe_en = en; bus.fe_rw = rw; bus.fe_be = be; bus.fe_addr = addr; bus.fe_wdata = wdata;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   last;
        logic done;
        logic [31:0] own_valid, own_rdata, oth_valid, oth_rdata;
        v    = vecs[idx];
        last = (v.lat < int'(TMO)) ? v.lat : int'(TMO);
        done = 1'b0;
        @(negedge clk);
        set_req(v.me, 1'b1, v.rw, v.be, v.addr, v.wdata);
        #1;
        chk($sformatf("v%0d idle_grant", idx), {30'b0, bus.grant}, 32'd0);
        chk($sformatf("v%0d idle_t_en", idx), {31'b0, bus.t_en}, 32'd0);
        for (int k = 1; k <= int'(TMO) && !done; k++) begin
            @(negedge clk);
            bus.t_valid = (k == v.lat);
            bus.t_rdata = v.rdata;
            #1;
            own_valid = v.me ? {31'b0, bus.me_valid} : {31'b0, bus.fe_valid};
            own_rdata = v.me ? bus.me_rdata : bus.fe_rdata;
            oth_valid = v.me ? {31'b0, bus.fe_valid} : {31'b0, bus.me_valid};
            oth_rdata = v.me ? bus.fe_rdata : bus.me_rdata;
            chk($sformatf("v%0d c%0d grant", idx, k), {30'b0, bus.grant}, v.me ? 32'd2 : 32'd1);
            chk($sformatf("v%0d c%0d t_en", idx, k), {31'b0, bus.t_en}, 32'd1);
            chk($sformatf("v%0d c%0d t_rw", idx, k), {31'b0, bus.t_rw}, {31'b0, v.rw});
            chk($sformatf("v%0d c%0d t_be", idx, k), {28'b0, bus.t_be}, {28'b0, v.be});
            chk($sformatf("v%0d c%0d t_addr", idx, k), bus.t_addr, v.addr);
            chk($sformatf("v%0d c%0d t_wdata", idx, k), bus.t_wdata, v.wdata);
            chk($sformatf("v%0d c%0d own_valid", idx, k), own_valid, (k == last) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d c%0d other_valid", idx, k), oth_valid, 32'd0);
            chk($sformatf("v%0d c%0d other_rdata", idx, k), oth_rdata, 32'd0);
            if (k == last) begin
                chk($sformatf("v%0d rdata", idx), own_rdata, v.exp_rdata);
                done = 1'b1;
            end
            if (k == 1) begin
                // Requester scrambles its inputs after the grant; target copy must not move.
                set_req(v.me, 1'b1, ~v.rw, ~v.be, ~v.addr, ~v.wdata);
            end
        end
        @(negedge clk);
        bus.t_valid = 1'b0;
        set_req(v.me, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk($sformatf("v%0d end_t_en", idx), {31'b0, bus.t_en}, 32'd0);
        chk($sformatf("v%0d end_grant", idx), {30'b0, bus.grant}, 32'd0);
        chk($sformatf("v%0d end_err", idx), {31'b0, bus.err}, {31'b0, v.exp_err});
    endtask

    task automatic tie_seq(input string tag, input logic first_me);
        logic cur_me;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        #1;
        chk({tag, " start_grant"}, {30'b0, bus.grant}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            cur_me = (s == 0) ? first_me : !first_me;
            @(negedge clk);
            bus.t_valid = 1'b1;
            bus.t_rdata = cur_me ? 32'h0000_00E0 : 32'h0000_00F0;
            #1;
            chk($sformatf("%s s%0d grant", tag, s), {30'b0, bus.grant}, cur_me ? 32'd2 : 32'd1);
            chk($sformatf("%s s%0d t_addr", tag, s), bus.t_addr, cur_me ? 32'h20 : 32'h10);
            chk($sformatf("%s s%0d me_valid", tag, s), {31'b0, bus.me_valid}, {31'b0, cur_me});
            chk($sformatf("%s s%0d fe_valid", tag, s), {31'b0, bus.fe_valid}, {31'b0, !cur_me});
            @(negedge clk);
            bus.t_valid = 1'b0;
            if (cur_me) bus.me_en = 1'b0;
            else        bus.fe_en = 1'b0;
            #1;
            chk($sformatf("%s s%0d idle_grant", tag, s), {30'b0, bus.grant}, 32'd0);
            chk($sformatf("%s s%0d idle_t_en", tag, s), {31'b0, bus.t_en}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{me:1'b0, rw:1'b0, be:4'hF, addr:32'h0000_0100, wdata:32'h0,
                    lat:4, rdata:32'h1234_5678, exp_rdata:32'h1234_5678, exp_err:1'b0};
        vecs[1] = '{me:1'b1, rw:1'b1, be:4'b0011, addr:32'h0000_2000, wdata:32'hAABB_CCDD,
                    lat:2, rdata:32'h0, exp_rdata:32'h0, exp_err:1'b0};
        vecs[2] = '{me:1'b1, rw:1'b0, be:4'b1100, addr:32'h0000_3004, wdata:32'h0,
                    lat:1, rdata:32'hCAFE_0001, exp_rdata:32'hCAFE_0001, exp_err:1'b0};
        vecs[3] = '{me:1'b0, rw:1'b0, be:4'hF, addr:32'h0000_0400, wdata:32'h0,
                    lat:8, rdata:32'h55AA_55AA, exp_rdata:32'h55AA_55AA, exp_err:1'b0};
        vecs[4] = '{me:1'b0, rw:1'b0, be:4'hF, addr:32'h0000_0500, wdata:32'h0,
                    lat:50, rdata:32'h1111_1111, exp_rdata:32'hDEAD_BEEF, exp_err:1'b1};
        vecs[5] = '{me:1'b1, rw:1'b0, be:4'h1, addr:32'h0000_0600, wdata:32'h0,
                    lat:3, rdata:32'h0BAD_F00D, exp_rdata:32'h0BAD_F00D, exp_err:1'b1};

        set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.t_valid = 1'b0;
        bus.t_rdata = 32'h0;

        #12;
        chk("rst t_en", {31'b0, bus.t_en}, 32'd0);
        chk("rst grant", {30'b0, bus.grant}, 32'd0);
        chk("rst err", {31'b0, bus.err}, 32'd0);
        chk("rst t_addr", bus.t_addr, 32'd0);
        chk("rst t_wdata", bus.t_wdata, 32'd0);
        chk("rst t_be_rw", {27'b0, bus.t_be, bus.t_rw}, 32'd0);
        chk("rst valids", {30'b0, bus.fe_valid, bus.me_valid}, 32'd0);
        @(negedge clk);
        res = 1'b1;

        tie_seq("tie1", 1'b1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Last served was the memory stage: round-robin hands the tie to fetch.
`ifdef DARK_ARB_RR_EN
        tie_seq("tie2", 1'b0);
`else
        tie_seq("tie2", 1'b1);
`endif

        // Reset in the middle of a memory-stage grant.
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
        @(negedge clk);
        #1;
        chk("mid grant", {30'b0, bus.grant}, 32'd2);
        chk("mid err_sticky", {31'b0, bus.err}, 32'd1);
        bus.t_valid = 1'b1;
        bus.t_rdata = 32'h7777_0000;
        res = 1'b0;
        #1;
        chk("mid rst t_en", {31'b0, bus.t_en}, 32'd0);
        chk("mid rst grant", {30'b0, bus.grant}, 32'd0);
        chk("mid rst err", {31'b0, bus.err}, 32'd0);
        chk("mid rst valids", {30'b0, bus.fe_valid, bus.me_valid}, 32'd0);
        chk("mid rst me_rdata", bus.me_rdata, 32'd0);
        @(negedge clk);
        bus.t_valid = 1'b0;
        res = 1'b1;
        #1;
        chk("rel grant", {30'b0, bus.grant}, 32'd0);
        @(negedge clk);
        bus.t_valid = 1'b1;
        bus.t_rdata = 32'h7777_0001;
        #1;
        chk("regrant grant", {30'b0, bus.grant}, 32'd2);
        chk("regrant t_en", {31'b0, bus.t_en}, 32'd1);
        chk("regrant t_addr", bus.t_addr, 32'h0000_0300);
        chk("regrant me_rdata", bus.me_rdata, 32'h7777_0001);
        @(negedge clk);
        bus.t_valid = 1'b0;
        bus.me_en = 1'b0;
        #1;
        chk("final grant", {30'b0, bus.grant}, 32'd0);
        chk("final err", {31'b0, bus.err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
